// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive and transmit paths.
// Contents: receiver FSM state encoding, frame data width, stop and idle line levels.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam logic        UART_STOP_LEVEL = 1'b1;
  localparam logic        UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } uart_state_e;

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for one asynchronous input bit. Flops reset to 1.
// Reusable for any async input that idles high.
// Ports:
//   i_clk   - system clock, rising edge
//   i_rst   - synchronous active-high reset
//   i_async - asynchronous input
//   o_sync  - synchronised output (last stage)
module uart_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/uart_recv.sv
// UART receiver, 8N1, LSB first, idle-high line. Start-bit timing is taken from the
// line itself; each bit is sampled at its centre by a local bit-period counter.
// Ports:
//   i_clk        - system clock, rising edge
//   i_rst        - synchronous active-high reset
//   i_uart_din   - asynchronous serial line, idle high
//   o_recv_data  - last good byte, held until the next good frame
//   o_recv_valid - one-cycle strobe, o_recv_data updated this cycle
//   o_frame_err  - one-cycle strobe, stop bit sampled low
//   o_recv_busy  - FSM not idle (includes waiting out a break)
module uart_recv
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_uart_din,
  output logic [UART_DATA_BITS-1:0] o_recv_data,
  output logic                      o_recv_valid,
  output logic                      o_frame_err,
  output logic                      o_recv_busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW = $clog2(UART_DATA_BITS);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] FullLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0] BitLast  = BitW'(UART_DATA_BITS - 1);

  logic                      w_rx_s;
  uart_state_e               r_state;
  logic [CntW-1:0]           r_clk_cnt;
  logic [BitW-1:0]           r_bit_cnt;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [UART_DATA_BITS-1:0] r_data;
  logic                      r_valid;
  logic                      r_err;

  uart_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_async(i_uart_din),
    .o_sync (w_rx_s)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      unique case (r_state)
        StIdle: begin
          r_clk_cnt <= '0;
          if (w_rx_s != UART_IDLE_LEVEL) begin
            r_state <= StStart;
          end
        end
        StStart: begin
          if (r_clk_cnt == HalfLast) begin
            r_clk_cnt <= '0;
            // A start bit that is gone by mid-bit was a glitch.
            if (w_rx_s == UART_IDLE_LEVEL) begin
              r_state <= StIdle;
            end else begin
              r_state   <= StData;
              r_bit_cnt <= '0;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CntW'(1);
          end
        end
        StData: begin
          if (r_clk_cnt == FullLast) begin
            r_clk_cnt <= '0;
            r_shift   <= {w_rx_s, r_shift[UART_DATA_BITS-1:1]};
            if (r_bit_cnt == BitLast) begin
              r_state <= StStop;
            end else begin
              r_bit_cnt <= r_bit_cnt + BitW'(1);
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CntW'(1);
          end
        end
        StStop: begin
          if (r_clk_cnt == FullLast) begin
            r_clk_cnt <= '0;
            if (w_rx_s == UART_STOP_LEVEL) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
              r_state <= StIdle;
            end else begin
              r_err   <= 1'b1;
              r_state <= StBreak;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CntW'(1);
          end
        end
        StBreak: begin
          // Hold off until the line returns high so a break cannot look like a start.
          r_clk_cnt <= '0;
          if (w_rx_s == UART_IDLE_LEVEL) begin
            r_state <= StIdle;
          end
        end
        default: begin
          r_state   <= StIdle;
          r_clk_cnt <= '0;
        end
      endcase
    end
  end

  assign o_recv_data  = r_data;
  assign o_recv_valid = r_valid;
  assign o_frame_err  = r_err;
  assign o_recv_busy  = (r_state != StIdle);

endmodule

// File: tb/tb_uart_recv.sv
module tb_uart_recv;

  localparam int unsigned CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b1;
  logic [7:0] recv_data;
  logic       recv_valid;
  logic       frame_err;
  logic       recv_busy;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int busy_cyc = 0;
  int overlap_cnt = 0;
  int valid_cyc = 0;
  logic [7:0] data_log[$];

  uart_recv #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (2)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_uart_din  (din),
    .o_recv_data (recv_data),
    .o_recv_valid(recv_valid),
    .o_frame_err (frame_err),
    .o_recv_busy (recv_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (recv_valid) begin
      valid_cnt++;
      valid_cyc = cyc;
      data_log.push_back(recv_data);
    end
    if (frame_err) err_cnt++;
    if (recv_busy) busy_cyc++;
    if (recv_valid && frame_err) overlap_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    din = v;
    tick(CPB);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic test_reset;
    int v0, e0;
    rst = 1'b1;
    din = 1'b1;
    tick(3);
    checks++;
    if (recv_data !== 8'h00) begin
      errors++; $display("FAIL reset_data: got %0h expected 00", recv_data);
    end
    checks++;
    if (recv_valid !== 1'b0 || frame_err !== 1'b0 || recv_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got v=%b e=%b b=%b expected 0 0 0",
               recv_valid, frame_err, recv_busy);
    end
    rst = 1'b0;
    v0 = valid_cnt; e0 = err_cnt;
    tick(200);
    checks++;
    if (valid_cnt - v0 != 0 || err_cnt - e0 != 0) begin
      errors++;
      $display("FAIL idle_strobes: got valid=%0d err=%0d expected 0 0",
               valid_cnt - v0, err_cnt - e0);
    end
    checks++;
    if (recv_busy !== 1'b0 || recv_data !== 8'h00) begin
      errors++;
      $display("FAIL idle_state: got busy=%b data=%0h expected 0 00", recv_busy, recv_data);
    end
  endtask

  task automatic test_single;
    int v0, e0, fall_cyc, lat;
    v0 = valid_cnt; e0 = err_cnt;
    fall_cyc = cyc;
    send_byte(8'hA5, 1'b1);
    tick(40);
    checks++;
    if (valid_cnt - v0 != 1) begin
      errors++; $display("FAIL single_count: got %0d expected 1", valid_cnt - v0);
    end
    checks++;
    if (recv_data !== 8'hA5) begin
      errors++; $display("FAIL single_data: got %0h expected a5", recv_data);
    end
    checks++;
    if (err_cnt - e0 != 0) begin
      errors++; $display("FAIL single_err: got %0d expected 0", err_cnt - e0);
    end
    lat = valid_cyc - fall_cyc;
    checks++;
    if (lat < 154 || lat > 156) begin
      errors++; $display("FAIL single_latency: got %0d expected 155", lat);
    end
  endtask

  task automatic test_back_to_back;
    int v0;
    logic [7:0] exp_b[3];
    exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h55;
    v0 = valid_cnt;
    for (int i = 0; i < 3; i++) send_byte(exp_b[i], 1'b1);
    tick(40);
    checks++;
    if (valid_cnt - v0 != 3) begin
      errors++; $display("FAIL b2b_count: got %0d expected 3", valid_cnt - v0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (data_log[v0 + i] !== exp_b[i]) begin
          errors++;
          $display("FAIL b2b_data%0d: got %0h expected %0h", i, data_log[v0 + i], exp_b[i]);
        end
      end
    end
  endtask

  task automatic test_glitch;
    int v0, e0, b0, bc;
    v0 = valid_cnt; e0 = err_cnt; b0 = busy_cyc;
    din = 1'b0;
    tick(5);
    din = 1'b1;
    tick(50);
    bc = busy_cyc - b0;
    checks++;
    if (bc < 1 || bc > 10) begin
      errors++; $display("FAIL glitch_busy: got %0d cycles expected 1..10", bc);
    end
    checks++;
    if (valid_cnt - v0 != 0 || err_cnt - e0 != 0 || recv_busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_strobes: got valid=%0d err=%0d busy=%b expected 0 0 0",
               valid_cnt - v0, err_cnt - e0, recv_busy);
    end
  endtask

  task automatic test_frame_err;
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    send_byte(8'h3C, 1'b0);
    tick(50);
    checks++;
    if (recv_busy !== 1'b1) begin
      errors++; $display("FAIL break_busy: got %b expected 1", recv_busy);
    end
    tick(50);
    din = 1'b1;
    tick(30);
    checks++;
    if (err_cnt - e0 != 1) begin
      errors++; $display("FAIL ferr_count: got %0d expected 1", err_cnt - e0);
    end
    checks++;
    if (valid_cnt - v0 != 0 || recv_data !== 8'h55) begin
      errors++;
      $display("FAIL ferr_data: got valid=%0d data=%0h expected 0 55", valid_cnt - v0, recv_data);
    end
    checks++;
    if (recv_busy !== 1'b0) begin
      errors++; $display("FAIL break_exit: got busy=%b expected 0", recv_busy);
    end
    send_byte(8'h81, 1'b1);
    tick(40);
    checks++;
    if (valid_cnt - v0 != 1 || recv_data !== 8'h81 || err_cnt - e0 != 1) begin
      errors++;
      $display("FAIL after_ferr: got valid=%0d data=%0h err=%0d expected 1 81 1",
               valid_cnt - v0, recv_data, err_cnt - e0);
    end
  endtask

  task automatic test_rst_midframe;
    int v0, e0;
    logic [7:0] b;
    b = 8'hC3;
    v0 = valid_cnt; e0 = err_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    din = b[4];
    tick(CPB / 2);
    // Transmitter is reset with the receiver, so the line returns to idle.
    rst = 1'b1;
    din = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++;
    if (recv_data !== 8'h00 || recv_busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state: got data=%0h busy=%b expected 00 0", recv_data, recv_busy);
    end
    tick(300);
    checks++;
    if (valid_cnt - v0 != 0 || err_cnt - e0 != 0) begin
      errors++;
      $display("FAIL midrst_strobes: got valid=%0d err=%0d expected 0 0",
               valid_cnt - v0, err_cnt - e0);
    end
    send_byte(8'h7E, 1'b1);
    tick(40);
    checks++;
    if (valid_cnt - v0 != 1 || recv_data !== 8'h7E) begin
      errors++;
      $display("FAIL midrst_next: got valid=%0d data=%0h expected 1 7e",
               valid_cnt - v0, recv_data);
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_rst_midframe();
    checks++;
    if (overlap_cnt != 0) begin
      errors++; $display("FAIL strobe_overlap: got %0d expected 0", overlap_cnt);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_recv.md
Name: uart_recv

Overview:
- UART receiver; the counterpart of the existing UART transmit path. Frame format: 8N1, LSB first, line idles high.
- Takes the asynchronous serial line, synchronises it, and recovers each frame with its own bit-period counter. Start-bit timing comes from the line itself, not from the shared baud generator.
- Each good byte is presented on a held data register with a one-cycle valid strobe. Bad frames are flagged with a frame-error strobe.
- Sits at the UART pin boundary, next to the send path, feeding the byte consumer (FIFO or controller).

Parameters:
- CLKS_PER_BIT, 434, clk cycles per bit period (50 MHz / 115200). Minimum legal value is 4.
- SYNC_STAGES, 2, flip-flop depth of the input synchroniser. Minimum is 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- uart_din  input  1  asynchronous serial line, idle high.
- recv_data  output  8  last correctly received byte. Held until the next good frame.
- recv_valid  output  1  one-cycle pulse; recv_data was updated this cycle.
- frame_err  output  1  one-cycle pulse; stop bit was sampled low.
- recv_busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Interface (already decided): one clock, clk. Reset rst is synchronous and active-high.
- Reset values: recv_data=8'h00, recv_valid=0, frame_err=0, recv_busy=0. Synchroniser flops reset to 1, so no false start is seen out of reset. FSM resets to IDLE; counters and shift register reset to 0.
- Reset asserted mid-frame aborts the frame: no strobe is emitted and recv_data is unchanged from its reset value.
- Synchroniser: SYNC_STAGES flops; the FSM sees only the last stage (rx_s). No data-path logic reads uart_din directly.
- Counters:
  - clk_cnt runs 0..CLKS_PER_BIT-1.
  - bit_cnt runs 0..7.
  - clk_cnt clears on every state change.
- IDLE:
  - rx_s==0 -> START, with clk_cnt=0.
- START:
  - At clk_cnt==CLKS_PER_BIT/2-1 (integer division), sample rx_s.
  - Sample 0 -> DATA, with bit_cnt=0.
  - Sample 1 -> IDLE. This is glitch rejection; no strobe is emitted.
- DATA:
  - At clk_cnt==CLKS_PER_BIT-1, shift rx_s into the shift register MSB and shift right (LSB-first assembly).
  - bit_cnt==7 at the sample -> STOP; otherwise bit_cnt++.
- STOP:
  - At clk_cnt==CLKS_PER_BIT-1, sample rx_s.
  - Sample 1: recv_data<=shift register, recv_valid=1 for exactly one cycle, -> IDLE.
  - Sample 0: frame_err=1 for one cycle, recv_data unchanged, -> BREAK.
- BREAK:
  - Wait until rx_s==1, then -> IDLE.
  - A held-low line (break) therefore produces exactly one frame_err and never a spurious start.
- Strobes are registered. They assert in the cycle after the stop sample edge. recv_valid and frame_err are never high together.
- Latency: strobe at SYNC_STAGES + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after the uart_din falling edge, ±1 cycle.
- Back-to-back frames: IDLE sees a new start in the cycle after the STOP->IDLE transition. The receiver tolerates a stop bit as short as half a bit period.
- Baud tolerance: centre sampling tolerates ±4% total clock mismatch over a frame.
- recv_busy = (state != IDLE). This includes BREAK.

Decomposition:
- Package uart_pkg:
  - state encoding enum (IDLE, START, DATA, STOP, BREAK);
  - UART_DATA_BITS=8;
  - UART_STOP_LEVEL=1'b1;
  - UART_IDLE_LEVEL=1'b1.
  - The transmit path shares the last three constants.
- One sub-module, uart_sync: parameterised SYNC_STAGES flop chain, reset value 1. It is reusable for any asynchronous input in the codebase.
- FSM, counters and output registers live in uart_recv.

Test Plan (CLKS_PER_BIT=16, SYNC_STAGES=2, bench drives uart_din at 16 clk per bit):
- Reset then idle line high for 200 cycles -> no strobes; recv_busy=0; recv_data=8'h00.
- Send 8'hA5 as a clean frame -> one recv_valid pulse about 155 cycles after the falling edge; recv_data=8'hA5; frame_err stays 0.
- Send 8'h00, 8'hFF, 8'h55 back-to-back with 1-bit stop, no idle gap -> three recv_valid pulses; data 00, FF, 55 in order.
- Low glitch of 5 cycles on idle line -> FSM returns to IDLE; no strobe; recv_busy high for at most 10 cycles.
- Frame 8'h3C with stop bit driven 0, then line held low 100 cycles, then high, then frame 8'h81 -> exactly one frame_err; recv_data stays at previous value; then recv_valid with 8'h81.
- Assert rst for 1 cycle during bit 4 of frame 8'hC3, then send 8'h7E -> no strobe for the aborted frame; recv_data=8'h00 after reset; then recv_valid with 8'h7E.
